// File: rtl/aes_key_mem.sv
// rtl/aes_key_mem.sv - AES key expansion and round-key store (AES-256 schedule enabled by AES_256_EN)
`timescale 1ns/1ps

module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];
endmodule

module aes_key_mem #(
    parameter int NUM_ROUND_KEYS = 15,
    parameter int AES_128_ROUNDS = 10,
    parameter int AES_256_ROUNDS = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic [255:0] key,
    input  logic         keylen,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready
);
`ifdef AES_256_EN
    localparam int NUM_ENTRIES = NUM_ROUND_KEYS;
`else
    localparam int NUM_ENTRIES = (AES_128_ROUNDS + 1 < NUM_ROUND_KEYS) ? AES_128_ROUNDS + 1 : NUM_ROUND_KEYS;
`endif

    // The final key is written in the last GEN cycle, which also returns to IDLE,
    // so completion and the return to ready happen on the same edge.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_GEN  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [3:0]   ctr_q, ctr_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         keylen_q, keylen_d;
    logic [127:0] key_hi_q, key_hi_d;
    logic [127:0] mem_q [NUM_ENTRIES];
    logic [127:0] mem_d [NUM_ENTRIES];
`ifdef AES_256_EN
    logic [127:0] key_lo_q, key_lo_d;
`else
    logic         unused_inputs;
    assign unused_inputs = ^{keylen, key[127:0]};
`endif

    logic [3:0]   last_round;
    logic [3:0]   ctr_m1, ctr_m2;
    logic [127:0] prev1, prev2, rk;
    logic [31:0]  sub_in, sub_out, t_word;
    logic [31:0]  w0, w1, w2, w3;
    logic [7:0]   rcon_next;
    logic         use_rcon;

    assign last_round = keylen_q ? 4'(AES_256_ROUNDS) : 4'(AES_128_ROUNDS);
    assign ready      = (state_q == ST_IDLE);
    assign round_key  = (round <= last_round && 32'(round) < NUM_ENTRIES) ? mem_q[round] : 128'h0;

    // One expansion step: odd AES-256 steps skip RotWord and rcon, AES-128 chains from the previous key.
    always_comb begin
        ctr_m1    = ctr_q - 4'd1;
        ctr_m2    = ctr_q - 4'd2;
        prev1     = mem_q[ctr_m1];
        prev2     = keylen_q ? mem_q[ctr_m2] : prev1;
        use_rcon  = !(keylen_q && ctr_q[0]);
        sub_in    = use_rcon ? {prev1[23:0], prev1[31:24]} : prev1[31:0];
        t_word    = sub_out ^ (use_rcon ? {rcon_q, 24'h0} : 32'h0);
        w0        = prev2[127:96] ^ t_word;
        w1        = prev2[95:64]  ^ w0;
        w2        = prev2[63:32]  ^ w1;
        w3        = prev2[31:0]   ^ w2;
        rk        = {w0, w1, w2, w3};
        rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sub_in[8*g +: 8]),
            .out_byte (sub_out[8*g +: 8])
        );
    end

    // Next-state logic for the FSM, key latch, rcon, counter and register file.
    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        rcon_d   = rcon_q;
        keylen_d = keylen_q;
        key_hi_d = key_hi_q;
`ifdef AES_256_EN
        key_lo_d = key_lo_q;
`endif
        mem_d    = mem_q;
        case (state_q)
            ST_IDLE: begin
                if (init) begin
                    key_hi_d = key[255:128];
`ifdef AES_256_EN
                    key_lo_d = key[127:0];
                    keylen_d = keylen;
`else
                    keylen_d = 1'b0;
`endif
                    rcon_d   = 8'h01;
                    ctr_d    = 4'd0;
                    state_d  = ST_INIT;
                end
            end
            ST_INIT: begin
                mem_d[0] = key_hi_q;
                ctr_d    = 4'd1;
`ifdef AES_256_EN
                if (keylen_q) begin
                    mem_d[1] = key_lo_q;
                    ctr_d    = 4'd2;
                end
`endif
                state_d = ST_GEN;
            end
            ST_GEN: begin
                if (32'(ctr_q) < NUM_ENTRIES) begin
                    mem_d[ctr_q] = rk;
                end
                ctr_d = ctr_q + 4'd1;
                if (use_rcon) begin
                    rcon_d = rcon_next;
                end
                if (ctr_q == last_round) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset clears every stored key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctr_q    <= 4'd0;
            rcon_q   <= 8'h01;
            keylen_q <= 1'b0;
            key_hi_q <= 128'h0;
`ifdef AES_256_EN
            key_lo_q <= 128'h0;
`endif
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem_q[i] <= 128'h0;
            end
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            rcon_q   <= rcon_d;
            keylen_q <= keylen_d;
            key_hi_q <= key_hi_d;
`ifdef AES_256_EN
            key_lo_q <= key_lo_d;
`endif
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_aes_key_mem.sv
// tb/tb_aes_key_mem.sv - self-checking bench for aes_key_mem
`timescale 1ns/1ps

module tb_aes_key_mem;
    logic         clk = 1'b0;
    logic         reset;
    logic         init;
    logic [255:0] key;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;

    int errors = 0;
    int checks = 0;

    localparam logic [255:0] K1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] K3 = {128'h000102030405060708090a0b0c0d0e0f, 128'hffeeddccbbaa99887766554433221100};

    typedef struct {
        string        name;
        logic [3:0]   rnd;
        logic [127:0] exp;
    } sb_t;

    typedef struct {
        string        name;
        logic [255:0] k;
        logic         kl;
        logic [3:0]   rnd;
        logic [127:0] exp;
    } vec_t;

    sb_t        sbq[$];
    vec_t       vecs[$];
    logic [7:0] sb_tab [256];

    always #50 clk = ~clk;

    aes_key_mem dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .key       (key),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .ready     (ready)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from first principles: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] calc_sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        if (a == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
    endfunction

    function automatic logic eff_len(input logic kl);
`ifdef AES_256_EN
        return kl;
`else
        return 1'b0 & kl;
`endif
    endfunction

    // Word-oriented key schedule as written in the AES standard.
    function automatic logic [127:0] ref_rk(input logic [255:0] k, input logic is256, input int r);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        int nk = is256 ? 8 : 4;
        int nr = is256 ? 14 : 10;
        if (r > nr) return 128'h0;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Pulses init from a falling edge and queues the expected contents of every index.
    task automatic start_init(input logic [255:0] k, input logic kl, input string tag);
        key    = k;
        keylen = kl;
        init   = 1'b1;
        for (int r = 0; r < 15; r++) begin
            sbq.push_back('{$sformatf("%s_r%0d", tag, r), 4'(r), ref_rk(k, eff_len(kl), r)});
        end
        @(negedge clk);
        init = 1'b0;
    endtask

    // Counts falling edges with ready low; optionally pulses a stray init mid-expansion.
    task automatic wait_ready(input string tag, input int exp_low, input int poke_at);
        int low = 0;
        int guard = 0;
        while (ready !== 1'b1 && guard < 60) begin
            low++;
            if (low == poke_at) begin
                key    = ~key;
                keylen = ~keylen;
                init   = 1'b1;
            end else begin
                init = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        init = 1'b0;
        check({tag, "_busy_cycles"}, 128'(low), 128'(exp_low));
    endtask

    task automatic drain();
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            round = e.rnd;
            #1;
            check(e.name, round_key, e.exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < 16; r++) begin
            round = 4'(r);
            #1;
            check($sformatf("%s_r%0d", tag, r), round_key, 128'h0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] cur_k;
        logic         cur_kl;
        bit           have = 0;

        for (int i = 0; i < 256; i++) sb_tab[i] = calc_sbox(8'(i));

        vecs.push_back('{"k128_r0",  K1, 1'b0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c});
        vecs.push_back('{"k128_r1",  K1, 1'b0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605});
        vecs.push_back('{"k128_r10", K1, 1'b0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
        vecs.push_back('{"k128_r11", K1, 1'b0, 4'd11, 128'h0});
        vecs.push_back('{"k128_r15", K1, 1'b0, 4'd15, 128'h0});
        vecs.push_back('{"k3_r10",   K3, 1'b0, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5});
`ifdef AES_256_EN
        vecs.push_back('{"k256_r0",  K2, 1'b1, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781});
        vecs.push_back('{"k256_r1",  K2, 1'b1, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4});
        vecs.push_back('{"k256_r2",  K2, 1'b1, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde});
        vecs.push_back('{"k256_r14", K2, 1'b1, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e});
        vecs.push_back('{"k128_after256_r11", K1, 1'b0, 4'd11, 128'h0});
        vecs.push_back('{"k128_after256_r14", K1, 1'b0, 4'd14, 128'h0});
`else
        vecs.push_back('{"kl_ignored_r0",  K2, 1'b1, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781});
        vecs.push_back('{"kl_ignored_r11", K2, 1'b1, 4'd11, 128'h0});
`endif

        reset  = 1'b1;
        init   = 1'b0;
        key    = '0;
        keylen = 1'b0;
        round  = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ready", 128'(ready), 128'h1);
        check_all_zero("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            if (!have || vecs[i].k != cur_k || vecs[i].kl != cur_kl) begin
                start_init(vecs[i].k, vecs[i].kl, vecs[i].name);
                wait_ready(vecs[i].name, eff_len(vecs[i].kl) ? 14 : 11, 0);
                drain();
                cur_k  = vecs[i].k;
                cur_kl = vecs[i].kl;
                have   = 1;
            end
            round = vecs[i].rnd;
            #1;
            check(vecs[i].name, round_key, vecs[i].exp);
        end

        start_init(K1, 1'b0, "ignore");
        wait_ready("ignore", 11, 3);
        drain();

        start_init(K3, 1'b0, "abort");
        sbq.delete();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ready", 128'(ready), 128'h1);
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("abort");
        start_init(K3, 1'b0, "after_abort");
        wait_ready("after_abort", 11, 0);
        drain();

        start_init(K1, 1'b0, "b2b_a");
        wait_ready("b2b_a", 11, 0);
        drain();
        start_init(K3, 1'b0, "b2b_b");
        wait_ready("b2b_b", 11, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
